// File: rtl/prbs_clk_div_pkg.sv
// Shared types and default constants for the prbs_clk_div divider bank.
package prbs_clk_div_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } ch_state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;

  // Channel-select width; a single-channel bank still gets a 1-bit select.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/prbs_clk_div_ch.sv
// One divider channel: OFF/RUN/PEND FSM, half-period counter, shadow divisor
// applied only at a wrap so the output never produces a short pulse.
module prbs_clk_div_ch
  import prbs_clk_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_sync,
  output logic             o_div_out,
  output logic             o_tick,
  output logic             o_active
);

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_shadow;
  logic             r_out;
  logic             r_tick;
  logic             r_active;

  ch_state_e        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_shadow_nxt;
  logic             w_out_nxt;
  logic             w_tick_nxt;
  logic             w_wrap;
  logic             w_load;
  logic [CNT_W-1:0] w_handover_div;

  assign w_load         = i_we && i_en;
  assign w_wrap         = (r_cnt >= r_div);
  assign w_handover_div = (r_state == ST_PEND) ? r_shadow : r_div;

  // Next-state and datapath: disable wins, then sync/wrap, then a RUN-time write goes to the shadow.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_div_nxt    = r_div;
    w_shadow_nxt = r_shadow;
    w_out_nxt    = r_out;
    w_tick_nxt   = 1'b0;
    if (i_we && !i_en) begin
      w_state_nxt = ST_OFF;
      w_cnt_nxt   = '0;
      w_out_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_RUN, ST_PEND: begin
          if (i_sync) begin
            w_cnt_nxt   = '0;
            w_out_nxt   = 1'b0;
            w_div_nxt   = w_handover_div;
            w_state_nxt = ST_RUN;
          end else if (w_wrap) begin
            w_cnt_nxt   = '0;
            w_tick_nxt  = 1'b1;
            w_out_nxt   = ~r_out;
            w_div_nxt   = w_handover_div;
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          if (w_load) begin
            w_shadow_nxt = i_div;
            w_state_nxt  = ST_PEND;
          end else begin
            w_shadow_nxt = r_shadow;
          end
        end
        ST_OFF: begin
          w_cnt_nxt = '0;
          w_out_nxt = 1'b0;
          if (w_load) begin
            w_div_nxt   = i_div;
            w_state_nxt = ST_RUN;
          end else begin
            w_div_nxt = r_div;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = '0;
          w_out_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_OFF;
      r_cnt    <= '0;
      r_div    <= '0;
      r_shadow <= '0;
      r_out    <= 1'b0;
      r_tick   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div    <= w_div_nxt;
      r_shadow <= w_shadow_nxt;
      r_out    <= w_out_nxt;
      r_tick   <= w_tick_nxt;
      r_active <= (w_state_nxt != ST_OFF);
    end
  end

  assign o_div_out = r_out;
  assign o_tick    = r_tick;
  assign o_active  = r_active;

endmodule

// File: rtl/prbs_clk_div.sv
// Bank of NUM_CH independent programmable clock dividers sharing one config port.
// Define PRBS_CLK_DIV_SYNC_EN to add sync_i for a phase-aligned restart of all active channels.
module prbs_clk_div
  import prbs_clk_div_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int CH_W   = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_en,
`ifdef PRBS_CLK_DIV_SYNC_EN
  input  logic              sync_i,
`endif
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] ch_active
);

  logic w_sync;

`ifdef PRBS_CLK_DIV_SYNC_EN
  assign w_sync = sync_i;
`else
  assign w_sync = 1'b0;
`endif

  // Out-of-range channel numbers match no instance and are dropped here.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_we;
    assign w_we = cfg_we && (cfg_ch == CH_W'(g));

    prbs_clk_div_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_we),
      .i_en      (cfg_en),
      .i_div     (cfg_div),
      .i_sync    (w_sync),
      .o_div_out (div_out[g]),
      .o_tick    (tick[g]),
      .o_active  (ch_active[g])
    );
  end

endmodule

// File: tb/tb_prbs_clk_div.sv
// Self-checking bench for prbs_clk_div: time-based channel model plus directed literal checks.
module tb_prbs_clk_div;

  localparam int NCH = 3;
  localparam int CW  = 4;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_div = '0;
  logic           cfg_en = 1'b0;
`ifdef PRBS_CLK_DIV_SYNC_EN
  logic           sync_i = 1'b0;
`endif
  logic [NCH-1:0] div_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] ch_active;

  int n_checks = 0;
  int n_errors = 0;

  prbs_clk_div #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
`ifdef PRBS_CLK_DIV_SYNC_EN
    .sync_i    (sync_i),
`endif
    .div_out   (div_out),
    .tick      (tick),
    .ch_active (ch_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each enabled channel is described by an anchor cycle t0, divisor and starting level.
  bit          m_en   [NCH];
  bit          m_base [NCH];
  bit          m_pend [NCH];
  int unsigned m_div  [NCH];
  int unsigned m_pdiv [NCH];
  int unsigned m_t0   [NCH];
  int unsigned cyc_n = 0;
  bit          m_valid = 1'b0;
  bit          e_out  [NCH];
  bit          e_tick [NCH];

  always @(negedge clk) begin : model_cmp
    int unsigned k;
    int unsigned p;
    bit t;
    bit o;
    bit s;
    cyc_n++;
    s = 1'b0;
`ifdef PRBS_CLK_DIV_SYNC_EN
    s = sync_i;
`endif
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_en[c] = 1'b0; m_pend[c] = 1'b0; e_out[c] = 1'b0; e_tick[c] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        t = 1'b0;
        o = 1'b0;
        if (m_en[c]) begin
          k = cyc_n - m_t0[c];
          p = m_div[c] + 1;
          t = (k > 0) && (k % p == 0);
          o = m_base[c] ^ ((k / p) % 2 == 1);
          if (t && m_pend[c]) begin
            m_t0[c] = cyc_n; m_div[c] = m_pdiv[c]; m_base[c] = o; m_pend[c] = 1'b0;
          end
          if (s) begin
            if (m_pend[c]) begin
              m_div[c] = m_pdiv[c]; m_pend[c] = 1'b0;
            end
            m_t0[c] = cyc_n; m_base[c] = 1'b0; t = 1'b0; o = 1'b0;
          end
        end
        if (cfg_we && int'(cfg_ch) == c) begin
          if (!cfg_en) begin
            m_en[c] = 1'b0; m_pend[c] = 1'b0; t = 1'b0; o = 1'b0;
          end else if (!m_en[c]) begin
            m_en[c] = 1'b1; m_div[c] = int'(cfg_div); m_t0[c] = cyc_n;
            m_base[c] = 1'b0; m_pend[c] = 1'b0; t = 1'b0; o = 1'b0;
          end else begin
            m_pend[c] = 1'b1; m_pdiv[c] = int'(cfg_div);
          end
        end
        e_out[c]  = o;
        e_tick[c] = t;
      end
    end
    if (m_valid) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("cyc%0d ch%0d div_out", cyc_n, c), 32'(div_out[c]), 32'(e_out[c]));
        chk($sformatf("cyc%0d ch%0d tick", cyc_n, c), 32'(tick[c]), 32'(e_tick[c]));
        chk($sformatf("cyc%0d ch%0d ch_active", cyc_n, c), 32'(ch_active[c]), 32'(m_en[c]));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input int ch, input int dv, input bit en);
    cfg_we  = 1'b1;
    cfg_ch  = CHW'(ch);
    cfg_div = CW'(dv);
    cfg_en  = en;
    cyc();
    cfg_we  = 1'b0;
  endtask

  logic [7:0] pat0_out;
  logic [7:0] pat0_tick;
  logic [8:0] pat1_out;
  logic [8:0] pat1_tick;

  initial begin
    pat0_out  = 8'b0111_1000;
    pat0_tick = 8'b1000_1000;
    pat1_out  = 9'b1_0011_0000;
    pat1_tick = 9'b1_0101_0000;

    run(3);
    chk("reset div_out", 32'(div_out), 32'd0);
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset ch_active", 32'(ch_active), 32'd0);
    rst_n = 1'b1;
    cyc();

    // ch0 div=3: toggles every 4 cycles, ticks at each toggle
    wr(0, 3, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("ch0 div3 k%0d out", k), 32'(div_out[0]), 32'(pat0_out[k-1]));
      chk($sformatf("ch0 div3 k%0d tick", k), 32'(tick[0]), 32'(pat0_tick[k-1]));
      chk($sformatf("ch0 div3 k%0d others", k), 32'(div_out[2:1]), 32'd0);
    end

    // write landing on the wrap edge completes the old wrap first
    run(3);
    wr(0, 1, 1'b1);
    chk("wrap+write tick", 32'(tick[0]), 32'd1);
    chk("wrap+write out", 32'(div_out[0]), 32'd1);
    run(10);

    // ch1 div=9 then div=1 mid-count: old half-period completes, no short pulse
    wr(1, 9, 1'b1);
    run(4);
    wr(1, 1, 1'b1);
    for (int j = 1; j <= 9; j++) begin
      cyc();
      chk($sformatf("ch1 pend j%0d out", j), 32'(div_out[1]), 32'(pat1_out[j-1]));
      chk($sformatf("ch1 pend j%0d tick", j), 32'(tick[1]), 32'(pat1_tick[j-1]));
    end

    // ch2 at maximum divisor, then disable while high
    wr(2, 15, 1'b1);
    run(20);
    chk("ch2 div15 high", 32'(div_out[2]), 32'd1);
    wr(2, 0, 1'b0);
    chk("ch2 off div_out", 32'(div_out[2]), 32'd0);
    chk("ch2 off tick", 32'(tick[2]), 32'd0);
    chk("ch2 off active", 32'(ch_active[2]), 32'd0);

    // out-of-range channel writes are ignored
    wr(3, 5, 1'b1);
    chk("oor en1 active", 32'(ch_active), 32'd3);
    wr(3, 0, 1'b0);
    chk("oor en0 active", 32'(ch_active), 32'd3);
    run(4);

    // back-to-back writes in PEND: last one wins
    wr(1, 7, 1'b1);
    wr(1, 2, 1'b1);
    run(20);

    // div=0 gives clk/2
    wr(0, 0, 1'b0);
    wr(0, 0, 1'b1);
    cyc();
    chk("div0 k1 out", 32'(div_out[0]), 32'd1);
    chk("div0 k1 tick", 32'(tick[0]), 32'd1);
    cyc();
    chk("div0 k2 out", 32'(div_out[0]), 32'd0);
    chk("div0 k2 tick", 32'(tick[0]), 32'd1);
    run(6);

    // one-cycle reset with a write presented: all off, write dropped
    wr(2, 4, 1'b1);
    run(5);
    rst_n = 1'b0; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 4'd3; cfg_en = 1'b1;
    cyc();
    rst_n = 1'b1; cfg_we = 1'b0;
    chk("mid reset div_out", 32'(div_out), 32'd0);
    chk("mid reset tick", 32'(tick), 32'd0);
    chk("mid reset active", 32'(ch_active), 32'd0);
    run(5);
    chk("post reset stays off", 32'(ch_active), 32'd0);

`ifdef PRBS_CLK_DIV_SYNC_EN
    wr(0, 2, 1'b1);
    wr(1, 5, 1'b1);
    run(7);
    sync_i = 1'b1;
    cyc();
    sync_i = 1'b0;
    chk("sync div_out", 32'(div_out[1:0]), 32'd0);
    chk("sync tick", 32'(tick[1:0]), 32'd0);
    for (int j = 1; j <= 6; j++) begin
      cyc();
      if (j == 2) chk("sync ch0 j2", 32'(div_out[0]), 32'd0);
      if (j == 3) chk("sync ch0 j3", 32'({tick[0], div_out[0]}), 32'd3);
      if (j == 5) chk("sync ch1 j5", 32'(div_out[1]), 32'd0);
      if (j == 6) chk("sync ch1 j6", 32'({tick[1], div_out[1]}), 32'd3);
    end
    run(4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
